sp_multi_ctx: RTL and testbench
===============================

Name: sp_multi_ctx

Overview:
- Parametrised stack-pointer unit; successor to the single fixed-width CPU stack pointer.
- Holds NUM_CTX independent stack pointers (one per hardware context/thread), each bounded to [SP_BASE, SP_BASE+STACK_DEPTH].
- Supports push/pop by a variable word step, direct load, and overflow/underflow detection with pulse and sticky error reporting.
- Sits between the decode/control stage (sp_op, sp_step) and the memory address mux (sp_addr).

Parameters:
- ADDR_W, 32, pointer/address width.
- SP_BASE, 32'h2000, reset and empty value of every pointer (lower bound).
- STACK_DEPTH, 256, words per stack; the upper bound is SP_BASE+STACK_DEPTH. Must be ≥1, and the upper bound must fit in ADDR_W.
- NUM_CTX, 4, number of contexts, ≥1.
- STEP_W, 4, width of the step field.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ctx_sel  in  max(1,$clog2(NUM_CTX))  active context for both the op and sp_addr
- sp_op  in  2  00 nop, 01 push (increment), 10 pop (decrement), 11 load
- sp_step  in  STEP_W  words moved by a push/pop
- sp_load_val  in  ADDR_W  new pointer value for a load
- err_clr  in  1  clears the sticky flags
- sp_addr  out  ADDR_W  pointer of ctx_sel
- sp_empty  out  1  sp_addr == SP_BASE
- sp_full  out  1  sp_addr == SP_BASE+STACK_DEPTH
- sp_used  out  $clog2(STACK_DEPTH+1)  sp_addr − SP_BASE
- err  out  1  one-cycle fault pulse
- ovf_sticky  out  1  overflow seen since the last clear
- unf_sticky  out  1  underflow/illegal load seen since the last clear

Behaviour:
- Reset (async, rst_n=0):
  - all NUM_CTX pointers = SP_BASE
  - err, ovf_sticky, unf_sticky = 0
  - sp_addr = SP_BASE, sp_empty = 1, sp_full = 0, sp_used = 0
  - Reset asserted mid-operation discards that operation.
- Read path:
  - sp_addr, sp_empty, sp_full and sp_used are combinational from the pointer register indexed by ctx_sel.
  - An op issued in cycle N is visible on sp_addr in cycle N+1 (same ctx_sel).
  - ctx_sel ≥ NUM_CTX selects context 0, for both read and op.
- Ops: at most one op per cycle, applied only to context ctx_sel; other contexts hold.
  - nop: hold; err=0 next cycle.
  - push: new = ptr + sp_step, computed at ADDR_W+1 bits (no wrap).
    - If new ≤ SP_BASE+STACK_DEPTH: ptr ← new.
    - Otherwise: ptr holds, err=1 for one cycle, ovf_sticky←1.
  - pop: computed at ADDR_W+1 bits.
    - If ptr − sp_step ≥ SP_BASE: ptr ← ptr − sp_step.
    - Otherwise: ptr holds, err pulse, unf_sticky←1.
  - push/pop with sp_step=0 behaves as nop: no change, no error.
  - load:
    - If SP_BASE ≤ sp_load_val ≤ SP_BASE+STACK_DEPTH: ptr ← sp_load_val.
    - If sp_load_val > upper bound: hold, err pulse, ovf_sticky←1.
    - If sp_load_val < SP_BASE: hold, err pulse, unf_sticky←1.
- Exact boundaries are legal:
  - push landing exactly on the upper bound
  - pop landing exactly on SP_BASE
  - load of SP_BASE or of the upper bound
- Faulting ops never modify any pointer.
- err: registered, high for exactly the cycle after each faulting op. Back-to-back faults keep it high on consecutive cycles.
- Sticky flags:
  - Set by faults; cleared by err_clr=1 at the clock edge.
  - If err_clr and a new fault occur in the same cycle, the fault wins: the corresponding flag is 1 afterwards and the other flag clears.
- No internal state machine beyond the per-context pointer registers and flags. Each op has single-cycle latency; no stalls.

Test Plan:
- Reset, then push step 1 on ctx 0 → next cycle sp_addr=0x2001, sp_used=1, sp_empty=0, err=0; ctx 1 still reads 0x2000.
- Load 0x20FE on ctx 2, then push step 2 → sp_addr=0x2100, sp_full=1, err=0. Then push step 1 → sp_addr stays 0x2100, err=1 for one cycle, ovf_sticky=1.
- Reset, then pop step 1 on ctx 3 → sp_addr=0x2000, err pulse, unf_sticky=1. Then pop step 0 → err=0, no change.
- Load 0x1FFF → hold, unf_sticky=1. Load 0x2101 → hold, ovf_sticky=1. Load 0x2000 → accepted, err=0.
- With ovf_sticky=1, assert err_clr together with an overflowing push → ovf_sticky remains 1. Then err_clr alone → both stickies 0.
- Push step 5 on ctx 1, assert rst_n=0 asynchronously mid-cycle → all outputs return immediately to reset values; ctx 1 reads 0x2000 after release.

Source files
------------

// File: rtl/sp_multi_ctx.sv
// ---------------------------------------------------------------------------
// sp_multi_ctx
//   Multi-context stack-pointer unit. Keeps NUM_CTX independent stack
//   pointers, each confined to [SP_BASE, SP_BASE+STACK_DEPTH]. Supports
//   push/pop by a variable word step and direct load. Any op that would
//   leave the legal window is refused: the pointer holds, a one-cycle
//   error pulse is raised and a sticky flag records the fault.
//
// Ports
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset
//   i_ctx_sel      context used by both the op and the read path
//                  (values >= NUM_CTX fall back to context 0)
//   i_sp_op        00 nop, 01 push, 10 pop, 11 load
//   i_sp_step      words moved by push/pop
//   i_sp_load_val  new pointer value for a load
//   i_err_clr      clears the sticky flags (a same-cycle fault wins)
//   o_sp_addr      pointer of the selected context (combinational)
//   o_sp_empty     pointer == SP_BASE
//   o_sp_full      pointer == SP_BASE+STACK_DEPTH
//   o_sp_used      pointer - SP_BASE
//   o_err          registered fault pulse, cycle after the faulting op
//   o_ovf_sticky   overflow seen since last clear
//   o_unf_sticky   underflow / too-low load seen since last clear
// ---------------------------------------------------------------------------
module sp_multi_ctx #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] SP_BASE     = 32'h2000,
    parameter int                STACK_DEPTH = 256,
    parameter int                NUM_CTX     = 4,
    parameter int                STEP_W      = 4,
    localparam int               CTX_W       = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
    localparam int               USED_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [CTX_W-1:0]  i_ctx_sel,
    input  logic [1:0]        i_sp_op,
    input  logic [STEP_W-1:0] i_sp_step,
    input  logic [ADDR_W-1:0] i_sp_load_val,
    input  logic              i_err_clr,
    output logic [ADDR_W-1:0] o_sp_addr,
    output logic              o_sp_empty,
    output logic              o_sp_full,
    output logic [USED_W-1:0] o_sp_used,
    output logic              o_err,
    output logic              o_ovf_sticky,
    output logic              o_unf_sticky
);

    // All bound arithmetic is done one bit wider than the address so that
    // a push near the top of the address space cannot wrap and look legal.
    localparam int               XW   = ADDR_W + 1;
    localparam logic [XW-1:0]    LO_X = {1'b0, SP_BASE};
    localparam logic [XW-1:0]    HI_X = LO_X + XW'(STACK_DEPTH);
    localparam logic [CTX_W:0]   NCTX = (CTX_W + 1)'(NUM_CTX);

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    function automatic logic above_hi(input logic [XW-1:0] v);
        return v > HI_X;
    endfunction

    function automatic logic below_lo(input logic [XW-1:0] v);
        return v < LO_X;
    endfunction

    logic [ADDR_W-1:0] r_sp [NUM_CTX];
    logic              r_err;
    logic              r_ovf;
    logic              r_unf;

    logic [CTX_W-1:0]  w_ctx;
    logic [ADDR_W-1:0] w_cur;
    logic [XW-1:0]     w_cur_x;
    logic [XW-1:0]     w_step_x;
    logic [XW-1:0]     w_ld_x;
    logic [XW-1:0]     w_sum;
    logic [XW-1:0]     w_diff;
    logic [ADDR_W-1:0] w_next;
    logic              w_we;
    logic              w_ovf;
    logic              w_unf;

    // Out-of-range context numbers alias context 0 for read and write alike.
    always_comb begin
        w_ctx = '0;
        if ({1'b0, i_ctx_sel} < NCTX) begin
            w_ctx = i_ctx_sel;
        end
    end

    assign w_cur    = r_sp[w_ctx];
    assign w_cur_x  = {1'b0, w_cur};
    assign w_step_x = XW'(i_sp_step);
    assign w_ld_x   = {1'b0, i_sp_load_val};
    assign w_sum    = w_cur_x + w_step_x;
    assign w_diff   = w_cur_x - w_step_x;

    // Pop underflow is tested as cur < base+step so the subtraction can
    // never wrap into a value that would pass the lower-bound check.
    always_comb begin
        w_next = w_cur;
        w_we   = 1'b0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        case (op_e'(i_sp_op))
            OP_PUSH: begin
                if (above_hi(w_sum)) begin
                    w_ovf = 1'b1;
                end else begin
                    w_we   = 1'b1;
                    w_next = w_sum[ADDR_W-1:0];
                end
            end
            OP_POP: begin
                if (w_cur_x < (LO_X + w_step_x)) begin
                    w_unf = 1'b1;
                end else begin
                    w_we   = 1'b1;
                    w_next = w_diff[ADDR_W-1:0];
                end
            end
            OP_LOAD: begin
                if (above_hi(w_ld_x)) begin
                    w_ovf = 1'b1;
                end else if (below_lo(w_ld_x)) begin
                    w_unf = 1'b1;
                end else begin
                    w_we   = 1'b1;
                    w_next = i_sp_load_val;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                r_sp[i] <= SP_BASE;
            end
        end else if (w_we) begin
            r_sp[w_ctx] <= w_next;
        end
    end

    // A fault in the same cycle as err_clr re-sets its own flag; the other
    // flag still clears.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_err <= w_ovf | w_unf;
            r_ovf <= w_ovf | (r_ovf & ~i_err_clr);
            r_unf <= w_unf | (r_unf & ~i_err_clr);
        end
    end

    assign o_sp_addr    = w_cur;
    assign o_sp_empty   = (w_cur_x == LO_X);
    assign o_sp_full    = (w_cur_x == HI_X);
    assign o_sp_used    = USED_W'(w_cur_x - LO_X);
    assign o_err        = r_err;
    assign o_ovf_sticky = r_ovf;
    assign o_unf_sticky = r_unf;

endmodule

// File: tb/tb_sp_multi_ctx.sv
// ---------------------------------------------------------------------------
// tb_sp_multi_ctx
//   Scoreboard bench for sp_multi_ctx. The driver issues one op per cycle,
//   pushes the expected outputs for that cycle (pointer view before the op
//   takes effect, flags resulting from the previous op) into a queue, then
//   advances a plain-arithmetic model. A separate monitor pops and compares
//   every cycle. NUM_CTX=3 so that ctx_sel=3 exercises the alias to ctx 0.
// ---------------------------------------------------------------------------
module tb_sp_multi_ctx;

    localparam int      NUM_CTX = 3;
    localparam longint  BASE    = 64'h2000;
    localparam longint  DEPTH   = 256;
    localparam longint  HI      = BASE + DEPTH;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] LOAD = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ctx_sel = '0;
    logic [1:0]  sp_op = '0;
    logic [3:0]  sp_step = '0;
    logic [31:0] sp_load_val = '0;
    logic        err_clr = 1'b0;
    logic [31:0] sp_addr;
    logic        sp_empty;
    logic        sp_full;
    logic [8:0]  sp_used;
    logic        err;
    logic        ovf_sticky;
    logic        unf_sticky;

    sp_multi_ctx #(
        .ADDR_W(32), .SP_BASE(32'h2000), .STACK_DEPTH(256),
        .NUM_CTX(NUM_CTX), .STEP_W(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ctx_sel(ctx_sel), .i_sp_op(sp_op),
        .i_sp_step(sp_step), .i_sp_load_val(sp_load_val), .i_err_clr(err_clr),
        .o_sp_addr(sp_addr), .o_sp_empty(sp_empty), .o_sp_full(sp_full),
        .o_sp_used(sp_used), .o_err(err), .o_ovf_sticky(ovf_sticky),
        .o_unf_sticky(unf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        empty;
        logic        full;
        logic [8:0]  used;
        logic        err;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t   sbq[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;

    // Reference model state
    longint m_sp [NUM_CTX];
    bit     m_err, m_ovf, m_unf;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CTX; i++) m_sp[i] = BASE;
        m_err = 0; m_ovf = 0; m_unf = 0;
    endtask

    // Drive one op on the falling edge, record what the DUT should show
    // during this cycle, then advance the model as the rising edge will.
    task automatic do_op(input int c, input logic [1:0] op, input int step,
                         input longint ldv, input bit clr);
        exp_t   e;
        int     k;
        longint cur;
        bit     o, u;
        @(negedge clk);
        cyc++;
        ctx_sel     = 2'(c);
        sp_op       = op;
        sp_step     = 4'(step);
        sp_load_val = 32'(ldv);
        err_clr     = clr;
        k   = (c >= NUM_CTX) ? 0 : c;
        cur = m_sp[k];
        e.cyc   = cyc;
        e.addr  = 32'(cur);
        e.empty = (cur == BASE);
        e.full  = (cur == HI);
        e.used  = 9'(cur - BASE);
        e.err   = m_err;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sbq.push_back(e);
        o = 0; u = 0;
        case (op)
            PUSH: if (cur + step > HI) o = 1; else m_sp[k] = cur + step;
            POP:  if (cur - step < BASE) u = 1; else m_sp[k] = cur - step;
            LOAD: if (ldv > HI) o = 1;
                  else if (ldv < BASE) u = 1;
                  else m_sp[k] = ldv;
            default: ;
        endcase
        m_err = o | u;
        m_ovf = o | (m_ovf & !clr);
        m_unf = u | (m_unf & !clr);
    endtask

    task automatic sync_reset();
        @(negedge clk);
        sp_op = NOP; err_clr = 0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    // Monitor: compares whenever the driver has posted an expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sp_addr",    e.cyc, sp_addr,          e.addr);
                chk("sp_empty",   e.cyc, 32'(sp_empty),    32'(e.empty));
                chk("sp_full",    e.cyc, 32'(sp_full),     32'(e.full));
                chk("sp_used",    e.cyc, 32'(sp_used),     32'(e.used));
                chk("err",        e.cyc, 32'(err),         32'(e.err));
                chk("ovf_sticky", e.cyc, 32'(ovf_sticky),  32'(e.ovf));
                chk("unf_sticky", e.cyc, 32'(unf_sticky),  32'(e.unf));
            end
        end
    end

    initial begin
        longint v;
        int     sel;
        int     wait_cnt;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Basic push and per-context isolation
        do_op(0, PUSH, 1, 0, 0);
        do_op(1, NOP, 0, 0, 0);
        do_op(0, NOP, 0, 0, 0);

        // Exact upper bound, then overflow
        do_op(2, LOAD, 0, 64'h20FE, 0);
        do_op(2, PUSH, 2, 0, 0);
        do_op(2, PUSH, 1, 0, 0);
        do_op(2, NOP, 0, 0, 0);
        do_op(2, NOP, 0, 0, 0);

        // Underflow on an aliased context, zero-step pop
        sync_reset();
        do_op(3, POP, 1, 0, 0);
        do_op(3, POP, 0, 0, 0);
        do_op(3, NOP, 0, 0, 0);

        // Load bounds
        do_op(1, LOAD, 0, 64'h1FFF, 0);
        do_op(1, LOAD, 0, 64'h2101, 0);
        do_op(1, LOAD, 0, 64'h2000, 0);
        do_op(1, LOAD, 0, 64'h2100, 0);
        do_op(1, NOP, 0, 0, 0);

        // Clear colliding with a fault, then a plain clear
        do_op(1, PUSH, 1, 0, 0);
        do_op(1, PUSH, 3, 0, 1);
        do_op(1, NOP, 0, 0, 1);
        do_op(1, NOP, 0, 0, 0);

        // Asynchronous reset in the middle of a cycle with flags set
        do_op(1, LOAD, 0, 64'h1000, 0);
        @(negedge clk);
        cyc++;
        ctx_sel = 2'd1; sp_op = PUSH; sp_step = 4'd5; err_clr = 0;
        #3 rst_n = 0;
        #1;
        chk("rst sp_addr",    cyc, sp_addr,         32'h2000);
        chk("rst sp_empty",   cyc, 32'(sp_empty),   32'd1);
        chk("rst sp_full",    cyc, 32'(sp_full),    32'd0);
        chk("rst sp_used",    cyc, 32'(sp_used),    32'd0);
        chk("rst err",        cyc, 32'(err),        32'd0);
        chk("rst ovf_sticky", cyc, 32'(ovf_sticky), 32'd0);
        chk("rst unf_sticky", cyc, 32'(unf_sticky), 32'd0);
        sbq.delete();
        model_reset();
        sp_op = NOP;
        @(negedge clk);
        rst_n = 1;
        do_op(1, NOP, 0, 0, 0);
        do_op(0, NOP, 0, 0, 0);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(0, 2);
            case (sel)
                0: v = BASE - 3 + $urandom_range(0, 6);
                1: v = HI - 3 + $urandom_range(0, 6);
                default: v = BASE + $urandom_range(0, 256);
            endcase
            do_op($urandom_range(0, 3), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 15), v, ($urandom_range(0, 7) == 0));
        end
        do_op(0, NOP, 0, 0, 0);

        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        #3;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
